exe_md_stage: RTL and testbench
===============================

Name: exe_md_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; sits between decode and memory stages on the standard valid/allowin handshake.
- Adds over the basic execute stage:
  - a HI/LO register pair;
  - MULT/MULTU with a parametrised latency;
  - DIV/DIVU on an iterative restoring divider;
  - MFHI/MFLO/MTHI/MTLO;
  - byte/halfword/word stores.
- Stalls itself while a multiply or divide is in flight and reports that stall on the forwarding bus.

Parameters:
- DATA_W, 32, datapath width (HI, LO, operands, result).
- MUL_CYCLES, 1, cycles a multiply holds the stage before ready_go (≥1).
- DS_TO_ES_BUS_WD, 147, width of the decode-to-execute bus.
- ES_TO_MS_BUS_WD, 75, width of the execute-to-memory bus.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ms_allowin  in  1  memory stage accepts
- es_allowin  out  1  this stage accepts
- ds_to_es_valid  in  1  decode output valid
- ds_to_es_bus  in  DS_TO_ES_BUS_WD  fields, MSB→LSB:
  - alu_op[11:0], md_op[3:0]{mult,multu,div,divu}, hilo_rd[1:0]{hi,lo}, hilo_wr[1:0]{hi,lo}
  - load_op, mem_we, mem_size[1:0], src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, src2_zext, gr_we
  - dest[4:0], imm[15:0], rs_value, rt_value, pc
- es_to_ms_valid  out  1  output valid
- es_to_ms_bus  out  ES_TO_MS_BUS_WD  {res_from_mem, mem_size[1:0], addr[1:0], gr_we, dest[4:0], result, pc}
- data_sram_en  out  1  constant 1
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  ALU result
- data_sram_wdata  out  32  store data, replicated per size
- back_to_id_stage_bus_from_exe  out  40  {block, result[31:0], es_valid, gr_we, dest[4:0]}

Behaviour:
- Reset values:
  - es_valid=0, HI=LO=0, divider/multiplier counters idle.
  - All outputs derived from these, so es_allowin=1, es_to_ms_valid=0, data_sram_wen=0.
- Handshake:
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - The bus register loads on ds_to_es_valid && es_allowin; es_valid loads ds_to_es_valid when es_allowin.
- Operand selection:
  - src1: {27'b0, imm[10:6]} if sa, else pc if src1_is_pc, else rs.
  - src2: imm if src2_is_imm, zero-extended when src2_zext and sign-extended otherwise; 8 if src2_is_8; else rt.
- es_ready_go:
  - 1 for ALU, memory and HI/LO-move ops.
  - Multiply: 0 for MUL_CYCLES cycles after the instruction enters (full 2*DATA_W product registered), then 1.
  - Divide: 0 until the divider signals done; DATA_W iteration cycles + 1 sign-fix cycle = 33 busy cycles.
- Divider start and data:
  - Starts on the first cycle es_valid && div/divu && idle.
  - Signed ops work on magnitudes; quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones, remainder = dividend (no trap).
  - 0x80000000 / -1: quotient 0x80000000, remainder 0.
  - Done holds until the instruction leaves; the divider then returns to idle.
- HI/LO update:
  - Written only on the leave cycle (es_valid && es_ready_go && ms_allowin), never while stalled.
  - mult: HI=upper, LO=lower; div: LO=quotient, HI=remainder.
  - mthi/mtlo write rs_value.
- Result mux: mfhi → HI, mflo → LO, otherwise ALU result.
- Stores:
  - data_sram_wen is nonzero only when es_valid && mem_we.
  - mem_size 0 (byte): wen = 1<<addr[1:0]; wdata = {4{rt[7:0]}}.
  - mem_size 1 (half): wen = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rt[15:0]}}; addr[0] ignored.
  - mem_size 2 (word): wen = 4'hf; wdata = rt.
- Forwarding: block = es_valid && (load_op || !es_ready_go || md_op != 0 || hilo_rd != 0 while busy). Decode must stall on a match.
- Reset mid-divide or mid-multiply: the operation aborts, HI/LO are unchanged from their reset value, and the counter clears the same cycle.

Decomposition:
- mycpu.h holds:
  - DS_TO_ES_BUS_WD and ES_TO_MS_BUS_WD;
  - md_op bit positions;
  - mem_size encodings (BYTE=0, HALF=1, WORD=2).
- Sub-module md_div: iterative restoring divider.
  - Ports: clk, reset, start, signed, x, y → busy, done, q, r; parametrised by DATA_W.
  - The multiplier stays inline as a registered product plus counter.

Test Plan:
- divu: rs=100, rt=7 with ms_allowin=1 → es_to_ms_valid low for 33 cycles, then LO=14, HI=2; a following mflo forwards 14.
- div: rs=-7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; div by zero: rs=5, rt=0 → LO=0xFFFFFFFF, HI=5.
- mult: rs=0x80000000, rt=2 → HI=0xFFFFFFFF, LO=0; multu with the same operands → HI=1, LO=0. With ms_allowin held low 3 extra cycles, HI/LO are written exactly once, on the leave cycle.
- sb to addr 0x1003 with rt=0x12345678 → wen=4'b1000, wdata=0x78787878; sh to 0x1002 → wen=4'b1100, wdata=0x56785678; es_valid=0 → wen=0.
- Reset asserted on divider cycle 10 → next cycle es_valid=0, es_allowin=1, HI=LO=0; a new divu then completes normally in 33 cycles.

Source files
------------

// File: rtl/exe_md_stage_pkg.sv
// Shared encodings for the execute stage: bus widths, decode bus layout,
// md/hilo/alu bit positions, store sizes and the divider state type.
package exe_md_stage_pkg;
  localparam int XLEN      = 32;
  localparam int DS_ES_WD  = 147;
  localparam int ES_MS_WD  = 75;

  // md_op = {mult, multu, div, divu}
  localparam int MD_MULT  = 3;
  localparam int MD_MULTU = 2;
  localparam int MD_DIV   = 1;
  localparam int MD_DIVU  = 0;

  // hilo_rd / hilo_wr = {hi, lo}
  localparam int HL_HI = 1;
  localparam int HL_LO = 0;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 2, ALU_SLTU = 3;
  localparam int ALU_AND = 4, ALU_NOR = 5, ALU_OR  = 6, ALU_XOR  = 7;
  localparam int ALU_SLL = 8, ALU_SRL = 9, ALU_SRA = 10, ALU_LUI = 11;

  typedef struct packed {
    logic [11:0]     alu_op;
    logic [3:0]      md_op;
    logic [1:0]      hilo_rd;
    logic [1:0]      hilo_wr;
    logic            load_op;
    logic            mem_we;
    logic [1:0]      mem_size;
    logic            src1_is_sa;
    logic            src1_is_pc;
    logic            src2_is_imm;
    logic            src2_is_8;
    logic            src2_zext;
    logic            gr_we;
    logic [4:0]      dest;
    logic [15:0]     imm;
    logic [XLEN-1:0] rs_value;
    logic [XLEN-1:0] rt_value;
    logic [XLEN-1:0] pc;
  } ds_es_t;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_FIX, DIV_DONE} div_state_t;
endpackage

// File: rtl/exe_md_stage_div.sv
// Iterative restoring divider: first iteration on the start edge, DATA_W-1 more,
// then one sign-fix cycle. Result is held in DONE until ack.
module md_div import exe_md_stage_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_signed,
  input  logic              ack,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r
);
  localparam int CW = $clog2(DATA_W + 1);

  div_state_t        state, state_nx;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rem, quo, dvs;
  logic [DATA_W-1:0] rem_cur, quo_cur, dvs_cur, rem_nx, quo_nx;
  logic [DATA_W:0]   trial;
  logic              q_neg, r_neg;

  always_comb begin
    state_nx = state;
    case (state)
      DIV_IDLE: if (start) state_nx = DIV_RUN;
      DIV_RUN:  if (cnt == CW'(DATA_W - 1)) state_nx = DIV_FIX;
      DIV_FIX:  state_nx = DIV_DONE;
      DIV_DONE: if (ack) state_nx = DIV_IDLE;
      default:  state_nx = DIV_IDLE;
    endcase
  end

  // In IDLE the step works straight off the operand magnitudes.
  always_comb begin
    rem_cur = rem;
    quo_cur = quo;
    dvs_cur = dvs;
    if (state == DIV_IDLE) begin
      rem_cur = '0;
      quo_cur = (is_signed && x[DATA_W-1]) ? -x : x;
      dvs_cur = (is_signed && y[DATA_W-1]) ? -y : y;
    end
    trial  = {rem_cur, quo_cur[DATA_W-1]} - {1'b0, dvs_cur};
    rem_nx = trial[DATA_W] ? {rem_cur[DATA_W-2:0], quo_cur[DATA_W-1]} : trial[DATA_W-1:0];
    quo_nx = {quo_cur[DATA_W-2:0], ~trial[DATA_W]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == DIV_IDLE && start) cnt <= CW'(1);
      else if (state == DIV_RUN)      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == DIV_IDLE && start) begin
      rem   <= rem_nx;
      quo   <= quo_nx;
      dvs   <= dvs_cur;
      q_neg <= is_signed && (x[DATA_W-1] ^ y[DATA_W-1]);
      r_neg <= is_signed && x[DATA_W-1];
    end else if (state == DIV_RUN) begin
      rem <= rem_nx;
      quo <= quo_nx;
    end else if (state == DIV_FIX) begin
      // Divide by zero: all-ones quotient; remainder already equals the dividend.
      quo <= (dvs == '0) ? '1 : (q_neg ? -quo : quo);
      rem <= r_neg ? -rem : rem;
    end
  end

  assign busy = (state == DIV_RUN) || (state == DIV_FIX);
  assign done = (state == DIV_DONE);
  assign q    = quo;
  assign r    = rem;
endmodule

// File: rtl/exe_md_stage.sv
// MIPS execute stage with HI/LO, multi-cycle multiply, iterative divide and
// sized stores. DATA_W must match the word width carried on the buses.
module exe_md_stage import exe_md_stage_pkg::*; #(
  parameter int DATA_W          = XLEN,
  parameter int MUL_CYCLES      = 1,
  parameter int DS_TO_ES_BUS_WD = DS_ES_WD,
  parameter int ES_TO_MS_BUS_WD = ES_MS_WD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  output logic [39:0]                back_to_id_stage_bus_from_exe
);
  localparam int MCW = $clog2(MUL_CYCLES + 1);

  logic                       es_valid, es_ready_go, es_leave;
  logic [DS_TO_ES_BUS_WD-1:0] ds_bus_r;
  ds_es_t                     d, d_in;
  logic [DATA_W-1:0]          src1, src2, alu_res, es_result, hi, lo;
  logic                       is_mul, is_div, md_busy, block;
  logic [MCW-1:0]             mul_cnt;
  logic [2*DATA_W-1:0]        mul_a, mul_b, mul_prod;
  logic                       div_start, div_busy, div_done;
  logic [DATA_W-1:0]          div_q, div_r;
  logic [3:0]                 wen_raw;

  assign d    = ds_bus_r;
  assign d_in = ds_to_es_bus;

  assign is_mul      = d.md_op[MD_MULT] | d.md_op[MD_MULTU];
  assign is_div      = d.md_op[MD_DIV]  | d.md_op[MD_DIVU];
  assign es_ready_go = is_mul ? (mul_cnt == '0) : (is_div ? div_done : 1'b1);
  assign es_allowin  = !es_valid || (es_ready_go && ms_allowin);
  assign es_leave    = es_valid && es_ready_go && ms_allowin;
  assign es_to_ms_valid = es_valid && es_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
      ds_bus_r <= '0;
    end else begin
      if (es_allowin) es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) ds_bus_r <= ds_to_es_bus;
    end
  end

  always_comb begin
    src1 = d.src1_is_sa ? DATA_W'(d.imm[10:6]) : (d.src1_is_pc ? d.pc : d.rs_value);
    if (d.src2_is_imm)    src2 = {{(DATA_W-16){d.imm[15] & ~d.src2_zext}}, d.imm};
    else if (d.src2_is_8) src2 = DATA_W'(8);
    else                  src2 = d.rt_value;
    alu_res = '0;
    if (d.alu_op[ALU_ADD])  alu_res |= src1 + src2;
    if (d.alu_op[ALU_SUB])  alu_res |= src1 - src2;
    if (d.alu_op[ALU_SLT])  alu_res |= DATA_W'($signed(src1) < $signed(src2));
    if (d.alu_op[ALU_SLTU]) alu_res |= DATA_W'(src1 < src2);
    if (d.alu_op[ALU_AND])  alu_res |= src1 & src2;
    if (d.alu_op[ALU_NOR])  alu_res |= ~(src1 | src2);
    if (d.alu_op[ALU_OR])   alu_res |= src1 | src2;
    if (d.alu_op[ALU_XOR])  alu_res |= src1 ^ src2;
    if (d.alu_op[ALU_SLL])  alu_res |= src2 << src1[4:0];
    if (d.alu_op[ALU_SRL])  alu_res |= src2 >> src1[4:0];
    if (d.alu_op[ALU_SRA])  alu_res |= $unsigned($signed(src2) >>> src1[4:0]);
    if (d.alu_op[ALU_LUI])  alu_res |= src2 << 16;
  end

  // Multiplier: counter armed as a mult enters; product re-registered while it runs.
  assign mul_a = {{DATA_W{d.md_op[MD_MULT] & d.rs_value[DATA_W-1]}}, d.rs_value};
  assign mul_b = {{DATA_W{d.md_op[MD_MULT] & d.rt_value[DATA_W-1]}}, d.rt_value};

  always_ff @(posedge clk) begin
    if (reset)
      mul_cnt <= '0;
    else if (ds_to_es_valid && es_allowin)
      mul_cnt <= (d_in.md_op[MD_MULT] | d_in.md_op[MD_MULTU]) ? MCW'(MUL_CYCLES) : '0;
    else if (mul_cnt != '0)
      mul_cnt <= mul_cnt - MCW'(1);
  end

  always_ff @(posedge clk) begin
    if (mul_cnt != '0) mul_prod <= mul_a * mul_b;
  end

  assign div_start = es_valid && is_div && !div_busy && !div_done;

  md_div #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .is_signed(d.md_op[MD_DIV]),
    .ack      (es_leave),
    .x        (d.rs_value),
    .y        (d.rt_value),
    .busy     (div_busy),
    .done     (div_done),
    .q        (div_q),
    .r        (div_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (es_leave) begin
      if (is_mul) begin
        hi <= mul_prod[2*DATA_W-1:DATA_W];
        lo <= mul_prod[DATA_W-1:0];
      end else if (is_div) begin
        hi <= div_r;
        lo <= div_q;
      end else begin
        if (d.hilo_wr[HL_HI]) hi <= d.rs_value;
        if (d.hilo_wr[HL_LO]) lo <= d.rs_value;
      end
    end
  end

  assign es_result = d.hilo_rd[HL_HI] ? hi : (d.hilo_rd[HL_LO] ? lo : alu_res);

  always_comb begin
    wen_raw         = 4'hf;
    data_sram_wdata = d.rt_value;
    case (d.mem_size)
      SZ_BYTE: begin
        wen_raw         = 4'b0001 << alu_res[1:0];
        data_sram_wdata = {4{d.rt_value[7:0]}};
      end
      SZ_HALF: begin
        wen_raw         = alu_res[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{d.rt_value[15:0]}};
      end
      default: ;
    endcase
  end

  assign data_sram_en   = 1'b1;
  assign data_sram_wen  = (es_valid && d.mem_we) ? wen_raw : 4'b0000;
  assign data_sram_addr = alu_res;

  assign es_to_ms_bus = {d.load_op, d.mem_size, alu_res[1:0], d.gr_we, d.dest, es_result, d.pc};

  assign md_busy = (mul_cnt != '0) || div_busy;
  assign block   = es_valid && (d.load_op || !es_ready_go ||
                   (md_busy && (d.md_op != '0 || d.hilo_rd != '0)));
  assign back_to_id_stage_bus_from_exe = {block, es_result, es_valid, d.gr_we, d.dest};
endmodule

// File: tb/tb_exe_md_stage.sv
// Directed bench for exe_md_stage: divide/multiply latency and HI/LO results,
// stores, and reset during a divide.
module tb_exe_md_stage;
  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [146:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [74:0]  es_to_ms_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic [39:0]  back_bus;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exe_md_stage dut (
    .clk                          (clk),
    .reset                        (reset),
    .ms_allowin                   (ms_allowin),
    .es_allowin                   (es_allowin),
    .ds_to_es_valid               (ds_to_es_valid),
    .ds_to_es_bus                 (ds_to_es_bus),
    .es_to_ms_valid               (es_to_ms_valid),
    .es_to_ms_bus                 (es_to_ms_bus),
    .data_sram_en                 (data_sram_en),
    .data_sram_wen                (data_sram_wen),
    .data_sram_addr               (data_sram_addr),
    .data_sram_wdata              (data_sram_wdata),
    .back_to_id_stage_bus_from_exe(back_bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [146:0] mk(input logic [11:0] alu, input logic [3:0] md,
                                      input logic [1:0] hrd, input logic [1:0] hwr,
                                      input logic we, input logic [1:0] sz, input logic imm_src,
                                      input logic gwe, input logic [15:0] imm,
                                      input logic [31:0] rs, input logic [31:0] rt);
    return {alu, md, hrd, hwr, 1'b0, we, sz, 1'b0, 1'b0, imm_src, 1'b0, 1'b0, gwe,
            5'd3, imm, rs, rt, 32'hbfc0_0100};
  endfunction

  function automatic logic [146:0] mk_md(input logic [3:0] md, input logic [31:0] rs,
                                         input logic [31:0] rt);
    return mk(12'h0, md, 2'b00, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0, rs, rt);
  endfunction

  function automatic logic [146:0] mk_mf(input logic rd_hi);
    return mk(12'h0, 4'h0, rd_hi ? 2'b10 : 2'b01, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0, 32'h0, 32'h0);
  endfunction

  // Presents b until accepted; returns #1 after the accepting edge.
  task automatic issue(input logic [146:0] b);
    int g;
    g = 0;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    while (!es_allowin && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) chk("issue_timeout", 64'(g), 64'd0);
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic wait_go(output int n);
    n = 0;
    while (!es_to_ms_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_md(input string tag, input logic [146:0] b, input int cyc,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(b);
    chk({tag, "_block"}, 64'(back_bus[39]), 64'd1);
    wait_go(n);
    chk({tag, "_stall"}, 64'(n), 64'(cyc));
    issue(mk_mf(1'b0));
    chk({tag, "_lo"}, 64'(back_bus[38:7]), 64'(el));
    chk({tag, "_lo_block"}, 64'(back_bus[39]), 64'd0);
    issue(mk_mf(1'b1));
    chk({tag, "_hi"}, 64'(back_bus[38:7]), 64'(eh));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ms_allowin = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_allowin", 64'(es_allowin), 64'd1);
    chk("rst_ms_valid", 64'(es_to_ms_valid), 64'd0);
    chk("rst_wen", 64'(data_sram_wen), 64'd0);
    chk("rst_en", 64'(data_sram_en), 64'd1);
    chk("rst_fwd", 64'({back_bus[39], back_bus[6]}), 64'd0);
    chk("rst_hilo", {dut.hi, dut.lo}, 64'd0);

    run_md("divu", mk_md(4'b0001, 32'd100, 32'd7), 33, 32'd2, 32'd14);
    run_md("div_neg", mk_md(4'b0010, 32'hffff_fff9, 32'd2), 33, 32'hffff_ffff, 32'hffff_fffd);
    run_md("div_zero", mk_md(4'b0010, 32'd5, 32'd0), 33, 32'd5, 32'hffff_ffff);
    run_md("div_ovf", mk_md(4'b0010, 32'h8000_0000, 32'hffff_ffff), 33, 32'd0, 32'h8000_0000);
    run_md("mult", mk_md(4'b1000, 32'h8000_0000, 32'd2), 1, 32'hffff_ffff, 32'h0);

    // multu held 3 extra cycles by the memory stage: HI/LO change only on leave.
    ms_allowin = 1'b0;
    issue(mk_md(4'b0100, 32'h8000_0000, 32'd2));
    chk("mulu_block", 64'(back_bus[39]), 64'd1);
    chk("mulu_c0_hi", 64'(dut.hi), 64'hffff_ffff);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("mulu_hold_valid", 64'(es_to_ms_valid), 64'd1);
      chk("mulu_hold_hi", 64'(dut.hi), 64'hffff_ffff);
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    ms_allowin = 1'b1;
    @(posedge clk); #1;
    chk("mulu_leave_hilo", {dut.hi, dut.lo}, {32'd1, 32'd0});
    chk("mulu_gone", 64'(back_bus[6]), 64'd0);
    issue(mk_mf(1'b1));
    chk("mulu_mfhi", 64'(back_bus[38:7]), 64'd1);
    @(posedge clk); #1;

    // Stores: rs=0x1000 plus imm offset, rt=0x12345678.
    issue(mk(12'h001, 4'h0, 2'b00, 2'b00, 1'b1, 2'd0, 1'b1, 1'b0, 16'd3, 32'h1000, 32'h1234_5678));
    chk("sb_wen", 64'(data_sram_wen), 64'b1000);
    chk("sb_wdata", 64'(data_sram_wdata), 64'h7878_7878);
    chk("sb_addr", 64'(data_sram_addr), 64'h1003);
    chk("sb_bus_addr", 64'(es_to_ms_bus[71:70]), 64'd3);
    issue(mk(12'h001, 4'h0, 2'b00, 2'b00, 1'b1, 2'd1, 1'b1, 1'b0, 16'd2, 32'h1000, 32'h1234_5678));
    chk("sh_hi_wen", 64'(data_sram_wen), 64'b1100);
    chk("sh_hi_wdata", 64'(data_sram_wdata), 64'h5678_5678);
    issue(mk(12'h001, 4'h0, 2'b00, 2'b00, 1'b1, 2'd1, 1'b1, 1'b0, 16'd1, 32'h1000, 32'h1234_5678));
    chk("sh_lo_wen", 64'(data_sram_wen), 64'b0011);
    issue(mk(12'h001, 4'h0, 2'b00, 2'b00, 1'b1, 2'd2, 1'b1, 1'b0, 16'd4, 32'h1000, 32'h1234_5678));
    chk("sw_wen", 64'(data_sram_wen), 64'hf);
    chk("sw_wdata", 64'(data_sram_wdata), 64'h1234_5678);
    @(posedge clk); #1;
    chk("idle_wen", 64'(data_sram_wen), 64'd0);

    // Reset on divider cycle 10 aborts the divide and clears HI/LO.
    issue(mk_md(4'b0001, 32'd100, 32'd7));
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("mid_div_stalled", 64'(es_to_ms_valid), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2_valid", 64'(back_bus[6]), 64'd0);
    chk("rst2_allowin", 64'(es_allowin), 64'd1);
    chk("rst2_hilo", {dut.hi, dut.lo}, 64'd0);
    run_md("divu_after_rst", mk_md(4'b0001, 32'd100, 32'd7), 33, 32'd2, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
